// File: rtl/osc_bank.sv
// osc_bank: time-multiplexed oscillator bank.
// One shared four-stage pipeline visits every voice once per frame:
//   S0 phase/envelope update and ROM address, S1 waveform shaping,
//   S2 envelope and amplitude scaling, S3 accumulation and output saturation.
module osc_bank #(
   parameter int N_VOICES = 8,
   parameter int WIDTH    = 24,
   parameter int PHASE_W  = 32,
   parameter int ENV_W    = 16,
   parameter int LUT_AW   = 10
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        sample_tick,
   input  logic                        cfg_we,
   input  logic [$clog2(N_VOICES)-1:0] cfg_voice,
   input  logic [PHASE_W-1:0]          cfg_inc,
   input  logic [1:0]                  cfg_shape,
   input  logic [7:0]                  cfg_amp,
   input  logic [N_VOICES-1:0]         gate,
   input  logic [ENV_W-1:0]            attack_rate,
   input  logic [ENV_W-1:0]            decay_rate,
   input  logic [ENV_W-1:0]            release_rate,
   input  logic [ENV_W-1:0]            sustain_level,
   output logic [LUT_AW-1:0]           rom_addr,
   input  logic signed [WIDTH-1:0]     rom_data,
   output logic signed [WIDTH-1:0]     out,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        overrun
);

   localparam int VW    = $clog2(N_VOICES);
   localparam int ACC_W = WIDTH + VW;
   localparam int CNT_W = $clog2(N_VOICES + 3);
   localparam int P1_W  = WIDTH + ENV_W + 1;
   localparam int P2_W  = P1_W + 9;

   localparam logic [ENV_W-1:0]        ENV_MAX = '1;
   localparam logic signed [WIDTH-1:0] W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] W_NMAX  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [2:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_DECAY,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   // per-voice configuration and state
   logic [PHASE_W-1:0] inc_reg   [N_VOICES];
   logic [1:0]         shape_reg [N_VOICES];
   logic [7:0]         amp_reg   [N_VOICES];
   logic [PHASE_W-1:0] phase_reg [N_VOICES];
   logic [ENV_W-1:0]   level_reg [N_VOICES];
   env_state_t         env_reg   [N_VOICES];

   // frame sequencing
   logic             busy_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             overrun_reg;
   logic             tick_accept;
   logic             s0_active;
   logic [VW-1:0]    s0_voice;

   assign tick_accept = sample_tick & ~busy_reg;
   // Voice 0 is handled in the tick cycle itself, voice k on cycle k after it.
   assign s0_active   = tick_accept | (busy_reg & (cnt_reg < CNT_W'(N_VOICES)));
   assign s0_voice    = tick_accept ? '0 : cnt_reg[VW-1:0];

   // Frame counter: busy covers cycles 1..N+2 after an accepted tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
      end else if (tick_accept) begin
         busy_reg <= 1'b1;
         cnt_reg  <= CNT_W'(1);
      end else if (busy_reg) begin
         if (cnt_reg == CNT_W'(N_VOICES + 2)) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // Sticky overrun: a tick arriving while a frame is still in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         overrun_reg <= 1'b0;
      else if (sample_tick && busy_reg)
         overrun_reg <= 1'b1;
   end

   // Configuration registers; a slot reading the voice this cycle sees old values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_VOICES; i++) begin
            inc_reg[i]   <= '0;
            shape_reg[i] <= '0;
            amp_reg[i]   <= '0;
         end
      end else if (cfg_we) begin
         inc_reg[cfg_voice]   <= cfg_inc;
         shape_reg[cfg_voice] <= cfg_shape;
         amp_reg[cfg_voice]   <= cfg_amp;
      end
   end

   // S0 combinational: envelope step and phase advance for the slot's voice.
   logic [PHASE_W-1:0] cur_phase, phase_base, phase_next;
   logic [ENV_W-1:0]   cur_level, level_next;
   env_state_t         cur_state, env_next;
   logic               cur_gate;
   logic [ENV_W:0]     atk_sum, dec_diff;
   logic [ENV_W-1:0]   atk_level, dec_level, rel_level;
   env_state_t         atk_state, rel_state;

   // Attack and release outcomes are shared by several FSM branches.
   always_comb begin
      cur_phase = phase_reg[s0_voice];
      cur_level = level_reg[s0_voice];
      cur_state = env_reg[s0_voice];
      cur_gate  = gate[s0_voice];

      atk_sum   = {1'b0, cur_level} + {1'b0, attack_rate};
      atk_level = cur_level;
      atk_state = ENV_ATTACK;
      if (attack_rate != '0) begin
         atk_level = atk_sum[ENV_W] ? ENV_MAX : atk_sum[ENV_W-1:0];
         if (atk_level == ENV_MAX)
            atk_state = ENV_DECAY;
      end

      dec_diff  = {1'b0, cur_level} - {1'b0, decay_rate};
      dec_level = (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] < sustain_level)) ?
                  sustain_level : dec_diff[ENV_W-1:0];

      rel_level = cur_level;
      rel_state = ENV_RELEASE;
      if (release_rate != '0) begin
         rel_level = (cur_level <= release_rate) ? '0 : (cur_level - release_rate);
         if (rel_level == '0)
            rel_state = ENV_IDLE;
      end
   end

   // Envelope FSM next state; gate-off has priority over the state's own step.
   always_comb begin
      env_next   = cur_state;
      level_next = cur_level;
      phase_base = cur_phase;
      case (cur_state)
         ENV_IDLE: begin
            if (cur_gate) begin
               phase_base = '0;
               env_next   = atk_state;
               level_next = atk_level;
            end
         end
         ENV_ATTACK: begin
            if (!cur_gate) begin
               env_next   = rel_state;
               level_next = rel_level;
            end else begin
               env_next   = atk_state;
               level_next = atk_level;
            end
         end
         ENV_DECAY: begin
            if (!cur_gate) begin
               env_next   = rel_state;
               level_next = rel_level;
            end else if (decay_rate != '0) begin
               level_next = dec_level;
               if (dec_level == sustain_level)
                  env_next = ENV_SUSTAIN;
            end
         end
         ENV_SUSTAIN: begin
            if (!cur_gate) begin
               env_next   = rel_state;
               level_next = rel_level;
            end else begin
               level_next = sustain_level;
            end
         end
         ENV_RELEASE: begin
            if (cur_gate) begin
               env_next   = atk_state;
               level_next = atk_level;
            end else begin
               env_next   = rel_state;
               level_next = rel_level;
            end
         end
         default: begin
            env_next   = ENV_IDLE;
            level_next = '0;
         end
      endcase
      phase_next = phase_base + inc_reg[s0_voice];
   end

   // S0 state write-back for the voice in the current slot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_VOICES; i++) begin
            phase_reg[i] <= '0;
            level_reg[i] <= '0;
            env_reg[i]   <= ENV_IDLE;
         end
      end else if (s0_active) begin
         phase_reg[s0_voice] <= phase_next;
         level_reg[s0_voice] <= level_next;
         env_reg[s0_voice]   <= env_next;
      end
   end

   // S0 pipeline register and ROM address.
   logic               a_valid, a_first, a_last;
   logic [1:0]         a_shape;
   logic [7:0]         a_amp;
   logic [ENV_W-1:0]   a_level;
   logic [PHASE_W-1:0] a_phase;
   logic [LUT_AW-1:0]  rom_addr_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_valid      <= 1'b0;
         a_first      <= 1'b0;
         a_last       <= 1'b0;
         a_shape      <= '0;
         a_amp        <= '0;
         a_level      <= '0;
         a_phase      <= '0;
         rom_addr_reg <= '0;
      end else begin
         a_valid <= s0_active;
         if (s0_active) begin
            a_first      <= (s0_voice == '0);
            a_last       <= (s0_voice == VW'(N_VOICES - 1));
            a_shape      <= shape_reg[s0_voice];
            a_amp        <= amp_reg[s0_voice];
            a_level      <= level_next;
            a_phase      <= phase_next;
            rom_addr_reg <= phase_next[PHASE_W-1 -: LUT_AW];
         end
      end
   end

   // S1 combinational: table-free waveforms; sine is taken from ROM a cycle later.
   logic signed [WIDTH-1:0] saw_w, sqr_w, tri_up, tri_w, wave_w;
   logic [WIDTH-1:0]        tri_u;

   always_comb begin
      saw_w  = {~a_phase[PHASE_W-1], a_phase[PHASE_W-2 -: WIDTH-1]};
      sqr_w  = a_phase[PHASE_W-1] ? W_NMAX : W_MAX;
      tri_u  = a_phase[PHASE_W-2 -: WIDTH];
      tri_up = {~tri_u[WIDTH-1], tri_u[WIDTH-2:0]};
      tri_w  = a_phase[PHASE_W-1] ? ~tri_up : tri_up;
      case (a_shape)
         2'd0:    wave_w = saw_w;
         2'd1:    wave_w = sqr_w;
         2'd2:    wave_w = tri_w;
         default: wave_w = '0;
      endcase
   end

   // S1 pipeline register.
   logic                    b_valid, b_first, b_last, b_sine;
   logic [7:0]              b_amp;
   logic [ENV_W-1:0]        b_level;
   logic signed [WIDTH-1:0] b_wave;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         b_valid <= 1'b0;
         b_first <= 1'b0;
         b_last  <= 1'b0;
         b_sine  <= 1'b0;
         b_amp   <= '0;
         b_level <= '0;
         b_wave  <= '0;
      end else begin
         b_valid <= a_valid;
         b_first <= a_first;
         b_last  <= a_last;
         b_sine  <= (a_shape == 2'd3);
         b_amp   <= a_amp;
         b_level <= a_level;
         b_wave  <= wave_w;
      end
   end

   // S2 combinational: full-precision envelope then amplitude scaling.
   logic signed [WIDTH-1:0] w_sel;
   logic signed [P1_W-1:0]  prod1, scaled1;
   logic signed [P2_W-1:0]  prod2;
   logic                    unused_bits;

   always_comb begin
      w_sel   = b_sine ? rom_data : b_wave;
      prod1   = P1_W'(w_sel) * P1_W'($signed({1'b0, b_level}));
      scaled1 = prod1 >>> ENV_W;
      prod2   = P2_W'(scaled1) * P2_W'($signed({1'b0, b_amp}));
   end

   assign unused_bits = ^{a_phase, prod2};

   // S2 pipeline register; the result always fits WIDTH bits.
   logic                    c_valid, c_first, c_last;
   logic signed [WIDTH-1:0] c_v;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_valid <= 1'b0;
         c_first <= 1'b0;
         c_last  <= 1'b0;
         c_v     <= '0;
      end else begin
         c_valid <= b_valid;
         c_first <= b_first;
         c_last  <= b_last;
         c_v     <= prod2[8 +: WIDTH];
      end
   end

   // S3 combinational: voice 0 restarts the sum so back-to-back frames never mix.
   logic signed [ACC_W-1:0] acc_reg, acc_base, acc_sum;
   logic signed [WIDTH-1:0] sat_w;

   always_comb begin
      acc_base = c_first ? '0 : acc_reg;
      acc_sum  = acc_base + ACC_W'(c_v);
      if (acc_sum > OUT_MAX)
         sat_w = OUT_MAX[WIDTH-1:0];
      else if (acc_sum < OUT_MIN)
         sat_w = OUT_MIN[WIDTH-1:0];
      else
         sat_w = acc_sum[WIDTH-1:0];
   end

   // S3 accumulator and saturated output on the last voice.
   logic signed [WIDTH-1:0] out_reg;
   logic                    out_valid_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_reg       <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= c_valid & c_last;
         if (c_valid) begin
            acc_reg <= acc_sum;
            if (c_last)
               out_reg <= sat_w;
         end
      end
   end

   assign rom_addr  = rom_addr_reg;
   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: directed, table-driven checks of the oscillator bank.
module tb_osc_bank;

   localparam longint FULL = 8388607;

   logic               clk = 1'b0;
   logic               rstn;
   logic               sample_tick;
   logic               cfg_we;
   logic [2:0]         cfg_voice;
   logic [31:0]        cfg_inc;
   logic [1:0]         cfg_shape;
   logic [7:0]         cfg_amp;
   logic [7:0]         gate;
   logic [15:0]        attack_rate, decay_rate, release_rate, sustain_level;
   logic [9:0]         rom_addr;
   logic signed [23:0] rom_data;
   logic signed [23:0] out;
   logic               out_valid, busy, overrun;

   logic signed [23:0] rom [1024];
   int                 addr_log [16];
   logic               busy_c1, busy_at_valid;
   int                 errors = 0;
   int                 checks = 0;

   typedef struct {
      logic        g;
      logic [15:0] lvl;
   } adsr_vec_t;
   adsr_vec_t adsr_tab [19];

   always #5 clk = ~clk;

   // synchronous sine ROM model, one cycle of read latency
   always @(posedge clk) rom_data <= rom[rom_addr];

   osc_bank dut (
      .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
      .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
      .cfg_shape(cfg_shape), .cfg_amp(cfg_amp), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .release_rate(release_rate), .sustain_level(sustain_level),
      .rom_addr(rom_addr), .rom_data(rom_data), .out(out),
      .out_valid(out_valid), .busy(busy), .overrun(overrun)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // ((w * level) >>> 16) * amp >>> 8 with floor shifts
   function automatic longint exp_v(input longint w, input longint lvl, input longint amp);
      longint p;
      p = (w * lvl) >>> 16;
      p = (p * amp) >>> 8;
      return p;
   endfunction

   task automatic do_reset();
      rstn = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
      cfg_inc = '0; cfg_shape = '0; cfg_amp = '0; gate = '0;
      attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic cfg_write(input int v, input logic [31:0] inc, input logic [1:0] sh,
                            input logic [7:0] a);
      @(negedge clk);
      cfg_we = 1'b1; cfg_voice = 3'(v); cfg_inc = inc; cfg_shape = sh; cfg_amp = a;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // One frame: tick in cycle 0, optional extra tick / cfg_inc write in a given cycle.
   task automatic run_frame(input int re_tick_at, input int cfg_at, input logic [31:0] new_inc,
                            output longint o, output int lat);
      lat = -1;
      o   = 0;
      @(negedge clk);
      sample_tick = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         sample_tick = (c == re_tick_at);
         cfg_we      = (c == cfg_at);
         if (c == cfg_at) cfg_inc = new_inc;
         addr_log[c] = int'(rom_addr);
         if (c == 1) busy_c1 = busy;
         if (out_valid && lat < 0) begin
            lat = c;
            o = out;
            busy_at_valid = busy;
         end
      end
   endtask

   initial begin
      longint o;
      int     lat;
      longint w;
      logic [31:0] p;
      int     cnt;

      for (int i = 0; i < 1024; i++) rom[i] = 24'(i * 16411 + 12345);
      adsr_tab[0]  = '{1'b1, 16'h4000}; adsr_tab[1]  = '{1'b1, 16'h8000};
      adsr_tab[2]  = '{1'b1, 16'hC000}; adsr_tab[3]  = '{1'b1, 16'hFFFF};
      adsr_tab[4]  = '{1'b1, 16'hEFFF}; adsr_tab[5]  = '{1'b1, 16'hDFFF};
      adsr_tab[6]  = '{1'b1, 16'hCFFF}; adsr_tab[7]  = '{1'b1, 16'hBFFF};
      adsr_tab[8]  = '{1'b1, 16'hAFFF}; adsr_tab[9]  = '{1'b1, 16'h9FFF};
      adsr_tab[10] = '{1'b1, 16'h8FFF}; adsr_tab[11] = '{1'b1, 16'h8000};
      adsr_tab[12] = '{1'b1, 16'h8000}; adsr_tab[13] = '{1'b0, 16'h6000};
      adsr_tab[14] = '{1'b0, 16'h4000}; adsr_tab[15] = '{1'b0, 16'h2000};
      adsr_tab[16] = '{1'b0, 16'h0000}; adsr_tab[17] = '{1'b0, 16'h0000};
      adsr_tab[18] = '{1'b1, 16'h4000};

      // reset state
      do_reset();
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rom_addr", rom_addr, 0);

      // silent frame
      run_frame(-1, -1, 32'h0, o, lat);
      check("idle_latency", lat, 11);
      check("idle_out", o, 0);
      check("idle_busy_c1", busy_c1, 1);
      check("idle_busy_at_valid", busy_at_valid, 0);
      check("idle_busy_after", busy, 0);

      // ADSR sequence on voice 0, square at phase 0 (constant +MAX)
      do_reset();
      attack_rate = 16'h4000; decay_rate = 16'h1000;
      sustain_level = 16'h8000; release_rate = 16'h2000;
      cfg_write(0, 32'h0, 2'd1, 8'd255);
      for (int i = 0; i < 19; i++) begin
         gate[0] = adsr_tab[i].g;
         run_frame(-1, -1, 32'h0, o, lat);
         check($sformatf("adsr%0d_out", i), o, exp_v(FULL, longint'(adsr_tab[i].lvl), 255));
         check($sformatf("adsr%0d_lat", i), lat, 11);
      end

      // saw on voice 0, 2^28 per frame: 16-frame wrap
      do_reset();
      attack_rate = 16'hFFFF; decay_rate = 16'h1000;
      sustain_level = 16'hFFFF; release_rate = 16'h1000;
      cfg_write(0, 32'h1000_0000, 2'd0, 8'd255);
      gate = 8'h01;
      for (int f = 1; f <= 17; f++) begin
         run_frame(-1, -1, 32'h0, o, lat);
         w = longint'(f % 16) * 1048576 - 8388608;
         check($sformatf("saw_f%0d", f), o, exp_v(w, 65535, 255));
      end

      // eight squares: saturation in both directions
      do_reset();
      attack_rate = 16'hFFFF; decay_rate = 16'h1000; sustain_level = 16'hFFFF;
      for (int v = 0; v < 8; v++) cfg_write(v, 32'h8000_0000, 2'd1, 8'd255);
      gate = 8'hFF;
      run_frame(-1, -1, 32'h0, o, lat);
      check("sat_neg", o, -8388608);
      run_frame(-1, -1, 32'h0, o, lat);
      check("sat_pos", o, 8388607);
      run_frame(-1, -1, 32'h0, o, lat);
      check("sat_neg2", o, -8388608);

      // overrun: tick on cycle 3 ignored, flag sticky
      do_reset();
      check("ovr_before", overrun, 0);
      run_frame(3, -1, 32'h0, o, lat);
      check("ovr_set", overrun, 1);
      check("ovr_latency", lat, 11);
      check("ovr_out", o, 0);
      run_frame(-1, -1, 32'h0, o, lat);
      check("ovr_sticky", overrun, 1);
      check("ovr_next_latency", lat, 11);

      // sine voice 2 via ROM; cfg_inc write in voice 2's own slot cycle
      do_reset();
      attack_rate = 16'hFFFF; decay_rate = 16'h1000; sustain_level = 16'hFFFF;
      cfg_write(2, 32'h0123_4567, 2'd3, 8'd200);
      gate = 8'h04;
      p = 32'h0123_4567;
      run_frame(-1, -1, 32'h0, o, lat);
      check("sine_f1_addr", addr_log[3], int'(p >> 22));
      check("sine_f1_out", o, exp_v(longint'(rom[p >> 22]), 65535, 200));
      p = p + 32'h0123_4567;
      run_frame(-1, 2, 32'h1000_0000, o, lat);
      check("sine_f2_addr", addr_log[3], int'(p >> 22));
      check("sine_f2_out", o, exp_v(longint'(rom[p >> 22]), 65535, 200));
      p = p + 32'h1000_0000;
      run_frame(-1, -1, 32'h0, o, lat);
      check("sine_f3_addr", addr_log[3], int'(p >> 22));
      check("sine_f3_out", o, exp_v(longint'(rom[p >> 22]), 65535, 200));

      // reset in mid-frame: no out_valid for the aborted frame
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out", out, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midrst_no_valid", cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
